// File: rtl/predictor_port_arbiter_if.sv
// Bundle of requester, predictor, response and statistics signals for predictor_port_arbiter.
// The arbiter uses the slave modport; the environment (requesters + predictor) uses master.
interface predictor_port_arbiter_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic                  req0_result;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic                  req1_result;
  logic                  req1_ready;
  logic                  pred_enable;
  logic [ADDR_WIDTH-1:0] pred_branch_address;
  logic                  pred_branch_result;
  logic                  pred_prediction;
  logic                  resp_valid;
  logic                  resp_id;
  logic                  resp_prediction;
  logic                  resp_hit;
  logic                  clear_stats;
  logic [CNT_WIDTH-1:0]  hits0;
  logic [CNT_WIDTH-1:0]  misses0;
  logic [CNT_WIDTH-1:0]  hits1;
  logic [CNT_WIDTH-1:0]  misses1;

  modport master (
    output req0_valid, req0_address, req0_result,
    output req1_valid, req1_address, req1_result,
    output pred_prediction, clear_stats,
    input  req0_ready, req1_ready,
    input  pred_enable, pred_branch_address, pred_branch_result,
    input  resp_valid, resp_id, resp_prediction, resp_hit,
    input  hits0, misses0, hits1, misses1
  );

  modport slave (
    input  req0_valid, req0_address, req0_result,
    input  req1_valid, req1_address, req1_result,
    input  pred_prediction, clear_stats,
    output req0_ready, req1_ready,
    output pred_enable, pred_branch_address, pred_branch_result,
    output resp_valid, resp_id, resp_prediction, resp_hit,
    output hits0, misses0, hits1, misses1
  );
endinterface

// File: rtl/predictor_port_arbiter.sv
// Round-robin sharing of one correlating predictor between two branch requesters.
// Each accepted branch runs handshake -> ISSUE -> CAPTURE -> one-cycle response strobe.
module predictor_port_arbiter #(
  parameter int ADDR_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input logic                     clk,
  input logic                     rst,
  predictor_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       id_q, id_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       result_q, result_d;
  logic                       pred_enable_q, pred_enable_d;
  logic                       resp_valid_q, resp_valid_d;
  logic                       resp_id_q, resp_id_d;
  logic                       resp_pred_q, resp_pred_d;
  logic                       resp_hit_q, resp_hit_d;
  logic [1:0][CNT_WIDTH-1:0]  hits_q, hits_d;
  logic [1:0][CNT_WIDTH-1:0]  misses_q, misses_d;
  logic                       grant_s;
  logic                       ready0_s;
  logic                       ready1_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  // Grant selection; ready is combinational and only offered in IDLE outside reset
  always_comb begin
    grant_s  = 1'b0;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    if (rst && (state_q == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_s = ~last_grant_q;
      end else begin
        grant_s = bus.req1_valid;
      end
      ready0_s = bus.req0_valid & ~grant_s;
      ready1_s = bus.req1_valid & grant_s;
    end else begin
      grant_s = 1'b0;
    end
  end

  // FSM next state, branch latch (which doubles as the predictor drive) and response
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    addr_d        = addr_q;
    result_d      = result_q;
    pred_enable_d = 1'b0;
    resp_valid_d  = 1'b0;
    resp_id_d     = resp_id_q;
    resp_pred_d   = resp_pred_q;
    resp_hit_d    = resp_hit_q;
    case (state_q)
      IDLE: begin
        if (ready0_s || ready1_s) begin
          state_d       = ISSUE;
          last_grant_d  = grant_s;
          id_d          = grant_s;
          addr_d        = grant_s ? bus.req1_address : bus.req0_address;
          result_d      = grant_s ? bus.req1_result : bus.req0_result;
          pred_enable_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_id_d    = id_q;
        resp_pred_d  = bus.pred_prediction;
        resp_hit_d   = bus.pred_prediction ~^ result_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Statistics: clear wins over the increment scored on the response cycle
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (bus.clear_stats) begin
      hits_d   = '0;
      misses_d = '0;
    end else if (resp_valid_q) begin
      if (resp_hit_q) begin
        hits_d[resp_id_q] = sat_inc(hits_q[resp_id_q]);
      end else begin
        misses_d[resp_id_q] = sat_inc(misses_q[resp_id_q]);
      end
    end else begin
      hits_d   = hits_q;
      misses_d = misses_q;
    end
  end

  // State and output registers; reset drops any in-flight branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      addr_q        <= '0;
      result_q      <= 1'b0;
      pred_enable_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_pred_q   <= 1'b0;
      resp_hit_q    <= 1'b0;
      hits_q        <= '0;
      misses_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      addr_q        <= addr_d;
      result_q      <= result_d;
      pred_enable_q <= pred_enable_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_pred_q   <= resp_pred_d;
      resp_hit_q    <= resp_hit_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
    end
  end

  assign bus.req0_ready          = ready0_s;
  assign bus.req1_ready          = ready1_s;
  assign bus.pred_enable         = pred_enable_q;
  assign bus.pred_branch_address = addr_q;
  assign bus.pred_branch_result  = result_q;
  assign bus.resp_valid          = resp_valid_q;
  assign bus.resp_id             = resp_id_q;
  assign bus.resp_prediction     = resp_pred_q;
  assign bus.resp_hit            = resp_hit_q;
  assign bus.hits0               = hits_q[0];
  assign bus.misses0             = misses_q[0];
  assign bus.hits1               = hits_q[1];
  assign bus.misses1             = misses_q[1];
endmodule

// File: tb/tb_predictor_port_arbiter.sv
// Self-checking bench for predictor_port_arbiter: directed scenarios plus random traffic
// checked against a cycle-timed reference model with a table-driven predictor stand-in.
module tb_predictor_port_arbiter;
  localparam int AW   = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic pred_table [0:(1<<AW)-1];
  logic force_en  = 1'b0;
  logic force_val = 1'b0;

  bit lg_m;
  int hits_m [2];
  int misses_m [2];

  predictor_port_arbiter_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  predictor_port_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Predictor stand-in: a fixed outcome per address unless the test forces a value
  assign bus.pred_prediction = force_en ? force_val : pred_table[bus.pred_branch_address];

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [4*CW-1:0] exp_cnt();
    return {CW'(hits_m[0]), CW'(misses_m[0]), CW'(hits_m[1]), CW'(misses_m[1])};
  endfunction

  function automatic logic [4*CW-1:0] act_cnt();
    return {bus.hits0, bus.misses0, bus.hits1, bus.misses1};
  endfunction

  task automatic score(input logic id, input logic hit);
    if (hit) hits_m[id] = sat(hits_m[id]);
    else     misses_m[id] = sat(misses_m[id]);
  endtask

  task automatic zero_model();
    hits_m[0] = 0; hits_m[1] = 0; misses_m[0] = 0; misses_m[1] = 0;
  endtask

  // Pure stimulus: one branch from one requester, returns on the response-strobe cycle
  task automatic send_one(input logic id, input logic [AW-1:0] a, input logic r);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_address = a; bus.req1_result = r;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_address = a; bus.req0_result = r;
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_address = AW'($urandom); bus.req0_result = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_address = AW'($urandom); bus.req1_result = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result, bus.resp_valid,
         bus.resp_id, bus.resp_prediction, bus.resp_hit, bus.req0_ready, bus.req1_ready,
         act_cnt()} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b addr=%h rv=%b rdy=%b%b cnt=%h, want all zero",
               bus.pred_enable, bus.pred_branch_address, bus.resp_valid,
               bus.req0_ready, bus.req1_ready, act_cnt());
    end
    rst = 1'b1;
    lg_m = 1'b1;
    zero_model();
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.pred_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_issue: got en=%b want 0", bus.pred_enable);
    end
  endtask

  task automatic test_single();
    logic p;
    p = pred_table[1];
    bus.req1_valid = 1'b1; bus.req1_address = AW'(1); bus.req1_result = 1'b1;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: got %b%b want 01", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    vectors++;
    if ({bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result} !== {1'b1, AW'(1), 1'b1}) begin
      miscompares++;
      $display("FAIL single_issue: got en=%b addr=%h res=%b want 1 1 1",
               bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result);
    end
    @(negedge clk);
    vectors++;
    if ({bus.pred_enable, bus.resp_valid, bus.pred_branch_address} !== {1'b0, 1'b0, AW'(1)}) begin
      miscompares++;
      $display("FAIL single_capture: got en=%b rv=%b addr=%h want 0 0 1",
               bus.pred_enable, bus.resp_valid, bus.pred_branch_address);
    end
    @(negedge clk);
    vectors++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit} !== {1'b1, 1'b1, p, p}) begin
      miscompares++;
      $display("FAIL single_resp: got %b%b%b%b want 11%b%b", bus.resp_valid, bus.resp_id,
               bus.resp_prediction, bus.resp_hit, p, p);
    end
    score(1'b1, p);
    lg_m = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.resp_valid, act_cnt()} !== {1'b0, exp_cnt()}) begin
      miscompares++;
      $display("FAIL single_count: got rv=%b cnt=%h want 0 %h", bus.resp_valid, act_cnt(), exp_cnt());
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] a [2];
    logic          r [2];
    logic          g;
    logic [AW-1:0] ea;
    logic          er;
    for (int i = 0; i < 2; i++) begin a[i] = AW'($urandom); r[i] = 1'($urandom); end
    for (int b = 0; b < 6; b++) begin
      bus.req0_valid = 1'b1; bus.req0_address = a[0]; bus.req0_result = r[0];
      bus.req1_valid = 1'b1; bus.req1_address = a[1]; bus.req1_result = r[1];
      g = ~lg_m;
      ea = a[g];
      er = r[g];
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== (g ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: got %b%b want grant %0d", b,
                 bus.req0_ready, bus.req1_ready, g);
      end
      lg_m = g;
      @(negedge clk);
      vectors++;
      if ({bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result,
           bus.req0_ready, bus.req1_ready} !== {1'b1, ea, er, 2'b00}) begin
        miscompares++;
        $display("FAIL contention_issue[%0d]: got en=%b addr=%h res=%b rdy=%b%b want 1 %h %b 00", b,
                 bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result,
                 bus.req0_ready, bus.req1_ready, ea, er);
      end
      a[g] = AW'($urandom);
      r[g] = 1'($urandom);
      @(negedge clk);
      vectors++;
      if ({bus.pred_enable, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
        miscompares++;
        $display("FAIL contention_capture[%0d]: got en=%b rdy=%b%b want 0 00", b,
                 bus.pred_enable, bus.req0_ready, bus.req1_ready);
      end
      @(negedge clk);
      vectors++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit} !==
          {1'b1, g, pred_table[ea], pred_table[ea] ~^ er}) begin
        miscompares++;
        $display("FAIL contention_resp[%0d]: got %b%b%b%b want 1%b%b%b", b, bus.resp_valid,
                 bus.resp_id, bus.resp_prediction, bus.resp_hit, g, pred_table[ea],
                 pred_table[ea] ~^ er);
      end
      score(g, pred_table[ea] ~^ er);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (act_cnt() !== exp_cnt()) begin
      miscompares++;
      $display("FAIL contention_count: got %h want %h", act_cnt(), exp_cnt());
    end
  endtask

  task automatic test_scoring();
    bus.clear_stats = 1'b1;
    @(negedge clk);
    bus.clear_stats = 1'b0;
    zero_model();
    vectors++;
    if (act_cnt() !== '0) begin
      miscompares++;
      $display("FAIL scoring_clear: got %h want 0", act_cnt());
    end
    force_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      force_val = 1'(k);
      send_one(1'b0, AW'($urandom), 1'b1);
      vectors++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit} !==
          {1'b1, 1'b0, 1'(k), 1'(k)}) begin
        miscompares++;
        $display("FAIL scoring_resp[%0d]: got %b%b%b%b want 10%0d%0d", k, bus.resp_valid,
                 bus.resp_id, bus.resp_prediction, bus.resp_hit, k, k);
      end
      score(1'b0, 1'(k));
      lg_m = 1'b0;
      @(negedge clk);
      vectors++;
      if (act_cnt() !== exp_cnt()) begin
        miscompares++;
        $display("FAIL scoring_count[%0d]: got %h want %h", k, act_cnt(), exp_cnt());
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_saturation_clear();
    force_en = 1'b1;
    force_val = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_one(1'b0, AW'($urandom), 1'b1);
      score(1'b0, 1'b1);
      lg_m = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if ({bus.hits0, act_cnt()} !== {CW'(CMAX), exp_cnt()}) begin
      miscompares++;
      $display("FAIL saturation: got hits0=%0d cnt=%h want %0d %h", bus.hits0, act_cnt(),
               CMAX, exp_cnt());
    end
    force_val = 1'b0;
    send_one(1'b1, AW'($urandom), 1'b1);
    lg_m = 1'b1;
    bus.clear_stats = 1'b1;
    @(negedge clk);
    bus.clear_stats = 1'b0;
    zero_model();
    vectors++;
    if ({act_cnt(), bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit} !==
        {exp_cnt(), 4'b0100}) begin
      miscompares++;
      $display("FAIL clear_vs_resp: got cnt=%h resp=%b%b%b%b want 0 0100", act_cnt(),
               bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit);
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_issue();
    logic [AW-1:0] a;
    logic          r;
    bus.req1_valid = 1'b1; bus.req1_address = AW'($urandom); bus.req1_result = 1'($urandom);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    vectors++;
    if (bus.pred_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL rstissue_pre: got en=%b want 1", bus.pred_enable);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.pred_enable, bus.resp_valid, act_cnt()} !== '0) begin
      miscompares++;
      $display("FAIL rstissue_async: got en=%b rv=%b cnt=%h want 0", bus.pred_enable,
               bus.resp_valid, act_cnt());
    end
    @(negedge clk);
    rst = 1'b1;
    lg_m = 1'b1;
    zero_model();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({bus.resp_valid, bus.pred_enable} !== 2'b00) begin
        miscompares++;
        $display("FAIL rstissue_quiet[%0d]: got rv=%b en=%b want 00", k, bus.resp_valid,
                 bus.pred_enable);
      end
    end
    a = AW'($urandom);
    r = 1'($urandom);
    bus.req0_valid = 1'b1; bus.req0_address = a; bus.req0_result = r;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstissue_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    vectors++;
    if ({bus.pred_enable, bus.pred_branch_address} !== {1'b1, a}) begin
      miscompares++;
      $display("FAIL rstissue_issue: got en=%b addr=%h want 1 %h", bus.pred_enable,
               bus.pred_branch_address, a);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit} !==
        {1'b1, 1'b0, pred_table[a], pred_table[a] ~^ r}) begin
      miscompares++;
      $display("FAIL rstissue_resp: got %b%b%b%b want 10%b%b", bus.resp_valid, bus.resp_id,
               bus.resp_prediction, bus.resp_hit, pred_table[a], pred_table[a] ~^ r);
    end
    score(1'b0, pred_table[a] ~^ r);
    lg_m = 1'b0;
    @(negedge clk);
    vectors++;
    if (act_cnt() !== exp_cnt()) begin
      miscompares++;
      $display("FAIL rstissue_count: got %h want %h", act_cnt(), exp_cnt());
    end
  endtask

  task automatic test_random(input int ncyc);
    logic          v [2];
    logic [AW-1:0] a [2];
    logic          r [2];
    int            hs_t;
    logic          e_id;
    logic [AW-1:0] e_a;
    logic          e_r;
    logic          g;
    logic          clr;
    logic [1:0]    exp_rdy;
    bit            hs;
    bit            resp_now;
    hs_t = -10;
    e_id = 1'b0; e_a = '0; e_r = 1'b0;
    for (int i = 0; i < 2; i++) begin v[i] = 1'b0; a[i] = '0; r[i] = 1'b0; end
    for (int t = 0; t < ncyc; t++) begin
      if (t == hs_t + 1) begin
        vectors++;
        if ({bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result} !== {1'b1, e_a, e_r}) begin
          miscompares++;
          $display("FAIL rand_issue t=%0d: got en=%b addr=%h res=%b want 1 %h %b", t,
                   bus.pred_enable, bus.pred_branch_address, bus.pred_branch_result, e_a, e_r);
        end
      end else begin
        vectors++;
        if (bus.pred_enable !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_enable t=%0d: got %b want 0", t, bus.pred_enable);
        end
      end
      resp_now = (t == hs_t + 3);
      if (resp_now) begin
        vectors++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_prediction, bus.resp_hit} !==
            {1'b1, e_id, pred_table[e_a], pred_table[e_a] ~^ e_r}) begin
          miscompares++;
          $display("FAIL rand_resp t=%0d: got %b%b%b%b want 1%b%b%b", t, bus.resp_valid,
                   bus.resp_id, bus.resp_prediction, bus.resp_hit, e_id, pred_table[e_a],
                   pred_table[e_a] ~^ e_r);
        end
      end else begin
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_rvalid t=%0d: got %b want 0", t, bus.resp_valid);
        end
      end
      vectors++;
      if (act_cnt() !== exp_cnt()) begin
        miscompares++;
        $display("FAIL rand_count t=%0d: got %h want %h", t, act_cnt(), exp_cnt());
      end
      clr = 1'b0;
      if (t < ncyc - 12) begin
        for (int i = 0; i < 2; i++) begin
          if (!v[i] && ($urandom_range(2) == 0)) begin
            v[i] = 1'b1; a[i] = AW'($urandom); r[i] = 1'($urandom);
          end
        end
        clr = ($urandom_range(15) == 0);
      end
      bus.req0_valid = v[0]; bus.req0_address = a[0]; bus.req0_result = r[0];
      bus.req1_valid = v[1]; bus.req1_address = a[1]; bus.req1_result = r[1];
      bus.clear_stats = clr;
      #1;
      hs = (t >= hs_t + 3) && (v[0] || v[1]);
      g = (v[0] && v[1]) ? ~lg_m : v[1];
      exp_rdy = hs ? (g ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== exp_rdy) begin
        miscompares++;
        $display("FAIL rand_ready t=%0d: got %b%b want %b", t, bus.req0_ready, bus.req1_ready, exp_rdy);
      end
      if (clr) zero_model();
      else if (resp_now) score(e_id, pred_table[e_a] ~^ e_r);
      if (hs) begin
        hs_t = t; e_id = g; e_a = a[g]; e_r = r[g]; lg_m = g; v[g] = 1'b0;
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.clear_stats = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) pred_table[i] = 1'($urandom);
    bus.req0_valid = 1'b0; bus.req0_address = '0; bus.req0_result = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_address = '0; bus.req1_result = 1'b0;
    bus.clear_stats = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_scoring();
    test_saturation_clear();
    test_reset_issue();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
